seg7_scan_controller: RTL

- Parametrised multiplexed seven-segment driver; successor to the fixed 8-digit display path.
- Integrates the refresh prescaler, per-digit decimal point, per-digit blanking, leading-zero suppression, PWM brightness and anti-ghost dead-time.
- Frame-synchronous shadow load prevents tearing.
- Sits between core debug/status registers and the board anode/cathode pins.

---
 rtl/seg7_scan_controller_if.sv | 26 ++
 rtl/seg7_scan_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller_if.sv
// rtl/seg7_scan_controller_if.sv - register-side and pin-side signal bundle of the seven-segment scan controller
interface seg7_scan_controller_if #(
    parameter int DIGITS   = 8,
    parameter int BRIGHT_W = 4
);
    logic                  enable;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     digit_en;
    logic                  blank_lz;
    logic [BRIGHT_W-1:0]   brightness;
    logic                  load;
    logic [DIGITS-1:0]     sel_led;
    logic [7:0]            led_value;
    logic                  frame_done;

    modport master (
        output enable, digits_in, dp_in, digit_en, blank_lz, brightness, load,
        input  sel_led, led_value, frame_done
    );

    modport slave (
        input  enable, digits_in, dp_in, digit_en, blank_lz, brightness, load,
        output sel_led, led_value, frame_done
    );
endinterface

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexed seven-segment scanner with frame-synchronous shadow load, LZ blanking, PWM and dead-time
module seg7_scan_controller #(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 20000,
    parameter int BLANK_CYCLES = 64,
    parameter int BRIGHT_W     = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    seg7_scan_controller_if.slave  bus
);
    localparam int SW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [SW-1:0]       SLOT_LAST    = SW'(CLK_DIV - 1);
    localparam logic [SW-1:0]       ACTIVE_START = SW'(BLANK_CYCLES);
    localparam logic [IW-1:0]       IDX_LAST     = IW'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] BRIGHT_FULL  = '1;

    logic [SW-1:0]       slot_cnt;
    logic [IW-1:0]       idx;
    logic [BRIGHT_W-1:0] pwm_cnt;

    logic [4*DIGITS-1:0] pend_digits, sh_digits;
    logic [DIGITS-1:0]   pend_dp, sh_dp;
    logic [DIGITS-1:0]   pend_mask, sh_mask;
    logic                pend_lz, sh_lz;
    logic                pend_valid;

    logic [DIGITS-1:0]   sel_led_q;
    logic [7:0]          led_value_q;
    logic                frame_done_q;

    logic                slot_last;
    logic                frame_end;
    logic [DIGITS-1:0]   lz_blank;
    logic                above_blank;
    logic [3:0]          digit_nib [DIGITS];
    logic                pwm_on;
    logic                anode_on;
    logic [6:0]          seg_code;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          led_next;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_last && (idx == IDX_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // Shadow only moves at the frame boundary; a load landing on that same cycle bypasses pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_mask   <= '1;
            pend_lz     <= 1'b0;
            pend_valid  <= 1'b0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_mask     <= '1;
            sh_lz       <= 1'b0;
        end else if (frame_end) begin
            pend_valid <= 1'b0;
            if (bus.load) begin
                sh_digits <= bus.digits_in;
                sh_dp     <= bus.dp_in;
                sh_mask   <= bus.digit_en;
                sh_lz     <= bus.blank_lz;
            end else if (pend_valid) begin
                sh_digits <= pend_digits;
                sh_dp     <= pend_dp;
                sh_mask   <= pend_mask;
                sh_lz     <= pend_lz;
            end
        end else if (bus.load) begin
            pend_digits <= bus.digits_in;
            pend_dp     <= bus.dp_in;
            pend_mask   <= bus.digit_en;
            pend_lz     <= bus.blank_lz;
            pend_valid  <= 1'b1;
        end
    end

    always_comb begin
        for (int g = 0; g < DIGITS; g++) begin
            digit_nib[g] = sh_digits[4*g +: 4];
        end
    end

    // A digit stays blank only while every digit above it is blank too; digit 0 always survives.
    always_comb begin
        lz_blank    = '0;
        above_blank = 1'b1;
        for (int g = DIGITS - 1; g >= 1; g--) begin
            above_blank = above_blank && (digit_nib[g] == 4'h0) && !sh_dp[g];
            lz_blank[g] = sh_lz && above_blank;
        end
    end

    always_comb begin
        seg_code = 7'h7F;
        case (digit_nib[idx])
            4'h0: seg_code = 7'h08;
            4'h1: seg_code = 7'h6D;
            4'h2: seg_code = 7'h22;
            4'h3: seg_code = 7'h24;
            4'h4: seg_code = 7'h45;
            4'h5: seg_code = 7'h14;
            4'h6: seg_code = 7'h10;
            4'h7: seg_code = 7'h2D;
            4'h8: seg_code = 7'h00;
            4'h9: seg_code = 7'h04;
            4'hA: seg_code = 7'h20;
            4'hB: seg_code = 7'h50;
            4'hC: seg_code = 7'h72;
            4'hD: seg_code = 7'h60;
            4'hE: seg_code = 7'h12;
            4'hF: seg_code = 7'h13;
            default: seg_code = 7'h7F;
        endcase
    end

    assign pwm_on   = (bus.brightness == BRIGHT_FULL) || (pwm_cnt < bus.brightness);
    assign anode_on = bus.enable && (slot_cnt >= ACTIVE_START) && pwm_on
                      && sh_mask[idx] && !lz_blank[idx];

    always_comb begin
        sel_next = '1;
        led_next = 8'hFF;
        if (anode_on) begin
            sel_next = ~(DIGITS'(1) << idx);
            led_next = {~sh_dp[idx], seg_code};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_led_q    <= '1;
            led_value_q  <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            sel_led_q    <= sel_next;
            led_value_q  <= led_next;
            frame_done_q <= frame_end;
        end
    end

    assign bus.sel_led    = sel_led_q;
    assign bus.led_value  = led_value_q;
    assign bus.frame_done = frame_done_q;
endmodule
